// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// multiplexed common-anode seven-segment display driver.
module count_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  Value,
    output logic [11:0] BCD,
    output logic        Busy,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_force;
    logic [7:0]      r_last;
    logic [7:0]      r_cap;
    logic [7:0]      r_shreg;
    logic [11:0]     r_scratch;
    logic [2:0]      r_bitcnt;
    logic [11:0]     r_bcd;
    logic            r_busy;
    logic [CW-1:0]   r_refresh;
    logic [1:0]      r_idx;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            w_start;
    logic [11:0]     w_adj;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [6:0]      w_glyph;
    logic [3:0]      w_an;
    logic            w_wrap;

    assign w_start = (r_state == IDLE) && (r_force || (Value != r_last));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT:   if (r_bitcnt == 3'd7) w_next = LATCH;
            LATCH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction applied before each shift so every nibble stays a valid BCD digit.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_force   <= 1'b1;
            r_last    <= 8'h00;
            r_cap     <= 8'h00;
            r_shreg   <= 8'h00;
            r_scratch <= 12'h000;
            r_bitcnt  <= 3'd0;
            r_bcd     <= 12'h000;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cap     <= Value;
                        r_shreg   <= Value;
                        r_scratch <= 12'h000;
                        r_bitcnt  <= 3'd0;
                        r_busy    <= 1'b1;
                        r_force   <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[10:0], r_shreg[7]};
                    r_shreg   <= {r_shreg[6:0], 1'b0};
                    r_bitcnt  <= r_bitcnt + 3'd1;
                end
                LATCH: begin
                    r_bcd  <= r_scratch;
                    r_last <= r_cap;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap = (r_refresh == REF_MAX);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
        end else if (w_wrap) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        w_an    = 4'b1110;
        case (r_idx)
            2'd1: begin
                w_digit = r_bcd[7:4];
                w_blank = BLANK_ZEROS && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
                w_an    = 4'b1101;
            end
            2'd2: begin
                w_digit = r_bcd[11:8];
                w_blank = BLANK_ZEROS && (r_bcd[11:8] == 4'd0);
                w_an    = 4'b1011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_digit)
            4'd0: w_glyph = 7'b1000000;
            4'd1: w_glyph = 7'b1111001;
            4'd2: w_glyph = 7'b0100100;
            4'd3: w_glyph = 7'b0110000;
            4'd4: w_glyph = 7'b0011001;
            4'd5: w_glyph = 7'b0010010;
            4'd6: w_glyph = 7'b0000010;
            4'd7: w_glyph = 7'b1111000;
            4'd8: w_glyph = 7'b0000000;
            4'd9: w_glyph = 7'b0010000;
            default: w_glyph = 7'b1111111;
        endcase
        if (w_blank) w_glyph = 7'b1111111;
    end

    // Anode and segment registers load together so a digit never shows its neighbour's glyph.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_an  <= 4'b1110;
            r_seg <= 7'b1000000;
        end else begin
            r_an  <= w_an;
            r_seg <= w_glyph;
        end
    end

    assign BCD   = r_bcd;
    assign Busy  = r_busy;
    assign Seg   = r_seg;
    assign An    = r_an;
    assign State = r_state;

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 8-bit T flip-flop counter output.
- Converts the binary count (0-255) to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the counter's Q bus and the board display pins.

Parameters:
- REFRESH_DIV, 100000: CLK cycles each digit stays lit before the scan advances (minimum 2).
- BLANK_ZEROS, 1: 1 blanks leading zeros in hundreds/tens; 0 shows all three digits.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- Value  input  8  binary count from the counter stage (its Q)
- BCD  output  12  latched BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones
- Busy  output  1  1 while a conversion is in progress
- Seg  output  7  active-low segments, Seg[0]=a ... Seg[6]=g
- An  output  4  active-low digit anodes; An[0] is the ones digit

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - BCD=12'h000, Busy=0, state=IDLE, force_conv=1, scan index=0, refresh counter=0
  - An=4'b1110, Seg=7'b1000000 (glyph "0")
- Conversion FSM, states IDLE, SHIFT, LATCH:
  - IDLE: if force_conv=1 or Value != last_value, capture Value into an 8-bit shift register, clear the 12-bit BCD scratch, clear the bit counter, set Busy=1, clear force_conv, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: once per cycle, add 3 to each scratch nibble that is >=5, then shift {scratch, shreg} left by 1. After exactly 8 SHIFT cycles go to LATCH.
  - LATCH: BCD <= scratch, last_value <= captured value, Busy <= 0, go to IDLE.
- Latency: Value change sampled in IDLE at edge N; Busy=1 from N to N+9; BCD updated at edge N+9.
  - A new conversion can start at edge N+10 at the earliest.
- Value changes during SHIFT/LATCH are ignored. The IDLE compare picks up the latest Value afterwards, so the final displayed result always matches a stable Value.
- BCD holds its previous result throughout a conversion; the display never shows partial values.
- Scan:
  - A refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0->1->2->0. Index 3 is never used.
  - An[3] is always 1.
  - An is a registered one-hot-low of the index: 1110, 1101, 1011.
  - Seg is registered in the same cycle as An. No ghosting: An and Seg change on the same edge.
- Decoder, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10-15 are unreachable; they map to 1111111.
- Blanking (BLANK_ZEROS=1):
  - Hundreds is blank (Seg=1111111) when 0.
  - Tens is blank when hundreds=0 and tens=0.
  - Ones is never blanked, so Value=0 shows "0".
- Reset mid-conversion aborts the conversion immediately. After release, the first cycle in IDLE forces a reconversion of the current Value.
- Value=255 gives BCD=12'h255; the scratch never overflows 12 bits.

Test Plan:
1. Reset low 3 cycles, release with Value=0, REFRESH_DIV=4: An=1110, Seg=1000000 during reset. Busy pulses for 9 cycles, then BCD=12'h000.
2. Value 0->8'd173 in IDLE: Busy=1 for edges N..N+9, BCD=12'h173 at N+9. Scan shows ones 0000111? No: ones is digit 3=0110000, tens 7=1111000, hundreds 1=1111001, order An 1110,1101,1011, each held 4 cycles.
3. Value=8'd255: BCD=12'h255. Value=8'd9 with BLANK_ZEROS=1: hundreds and tens Seg=1111111, ones=0010000.
4. Value changes 10->20 during SHIFT (cycle N+3): BCD=12'h010 at N+9. A second conversion starts at N+10, giving BCD=12'h020 at N+19.
5. Assert Reset during SHIFT: Busy=0, BCD=000 asynchronously. After release with Value=8'd42, BCD=12'h042 ten cycles later.
6. Hold Value constant for 100 cycles after conversion: Busy stays 0, no reconversion. An cycles only through 1110/1101/1011; An[3] never 0.
